// File: rtl/water_dispenser_pkg.sv
// Shared types and sizing helpers for the water dispenser controller.
// Latency: n/a. Backpressure: n/a.
package water_dispenser_pkg;

    typedef enum logic [1:0] {
        ENTRY,
        DISPENSE,
        DONE
    } state_t;

    localparam int DEFAULT_SWITCH_COUNT = 10;
    localparam int DEFAULT_MAX_DIGITS   = 4;
    localparam int DEFAULT_MAX_AMOUNT   = 2000;
    localparam int DEFAULT_TICKS_PER_ML = 1000;

    // Bits needed to hold any decimal number of max_digits digits.
    function automatic int amount_width(input int max_digits);
        int p;
        p = 1;
        for (int i = 0; i < max_digits; i++) begin
            p = p * 10;
        end
        return $clog2(p);
    endfunction

endpackage

// File: rtl/button_edge_detector.sv
// One-register rising-edge detector for a level front-panel button.
// Latency: pulse is combinational from the input against the previous sample. Backpressure: none.
module button_edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic pulse
);

    logic button_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            button_q <= 1'b0;
        end else begin
            button_q <= button;
        end
    end

    assign pulse = button & ~button_q;

endmodule

// File: rtl/water_dispenser_controller.sv
// Keypad volume entry, OK validation and metered valve control; button_delete exists only with WATER_DISPENSER_BACKSPACE_EN.
// Latency: actions register one clock after a button edge. Backpressure: none; button edges outside their state are dropped.
module water_dispenser_controller
    import water_dispenser_pkg::*;
#(
    parameter  int SWITCH_COUNT = DEFAULT_SWITCH_COUNT,
    parameter  int MAX_DIGITS   = DEFAULT_MAX_DIGITS,
    parameter  int MAX_AMOUNT   = DEFAULT_MAX_AMOUNT,
    parameter  int TICKS_PER_ML = DEFAULT_TICKS_PER_ML,
    localparam int AMOUNT_W     = amount_width(MAX_DIGITS),
    localparam int COUNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SWITCH_COUNT-1:0] switches,
    input  logic                    button_add,
    input  logic                    button_ok,
    input  logic                    button_cancel,
`ifdef WATER_DISPENSER_BACKSPACE_EN
    input  logic                    button_delete,
`endif
    output logic [AMOUNT_W-1:0]     entered_amount,
    output logic [COUNT_W-1:0]      digit_count,
    output logic [AMOUNT_W-1:0]     dispensed_amount,
    output logic                    valve_open,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int TICK_W = (TICKS_PER_ML > 1) ? $clog2(TICKS_PER_ML) : 1;
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICKS_PER_ML - 1);
    localparam logic [AMOUNT_W-1:0] TEN       = AMOUNT_W'(10);
    localparam logic [AMOUNT_W-1:0] AMOUNT_MAX = AMOUNT_W'(MAX_AMOUNT);
    localparam logic [COUNT_W-1:0]  DIGITS_MAX = COUNT_W'(MAX_DIGITS);

    state_t              state;
    logic [TICK_W-1:0]   tick;
    logic                add_edge;
    logic                ok_edge;
    logic                cancel_edge;
    logic                sw_any;
    logic [3:0]          sw_idx;
    logic [AMOUNT_W-1:0] appended_amount;
    logic [AMOUNT_W-1:0] dispensed_next;
    logic                amount_valid;
    logic                tick_wrap;

    button_edge_detector u_add_edge (
        .clock  (clock),
        .reset  (reset),
        .button (button_add),
        .pulse  (add_edge)
    );

    button_edge_detector u_ok_edge (
        .clock  (clock),
        .reset  (reset),
        .button (button_ok),
        .pulse  (ok_edge)
    );

    button_edge_detector u_cancel_edge (
        .clock  (clock),
        .reset  (reset),
        .button (button_cancel),
        .pulse  (cancel_edge)
    );

`ifdef WATER_DISPENSER_BACKSPACE_EN
    logic delete_edge;

    button_edge_detector u_delete_edge (
        .clock  (clock),
        .reset  (reset),
        .button (button_delete),
        .pulse  (delete_edge)
    );
`endif

    // Lowest asserted switch index is the digit.
    always_comb begin
        sw_any = 1'b0;
        sw_idx = 4'd0;
        for (int i = SWITCH_COUNT - 1; i >= 0; i--) begin
            if (switches[i]) begin
                sw_any = 1'b1;
                sw_idx = 4'(i);
            end
        end
    end

    assign appended_amount = entered_amount * TEN + AMOUNT_W'(sw_idx);
    assign dispensed_next  = dispensed_amount + AMOUNT_W'(1);
    assign amount_valid    = (entered_amount != '0) && (entered_amount <= AMOUNT_MAX);
    assign tick_wrap       = (tick == TICK_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= ENTRY;
            tick             <= '0;
            entered_amount   <= '0;
            digit_count      <= '0;
            dispensed_amount <= '0;
            valve_open       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            unique case (state)
                ENTRY: begin
                    if (cancel_edge) begin
                        entered_amount <= '0;
                        digit_count    <= '0;
                    end else if (ok_edge) begin
                        if (amount_valid) begin
                            dispensed_amount <= '0;
                            tick             <= '0;
                            valve_open       <= 1'b1;
                            busy             <= 1'b1;
                            state            <= DISPENSE;
                        end else begin
                            error          <= 1'b1;
                            entered_amount <= '0;
                            digit_count    <= '0;
                        end
                    end else if (add_edge) begin
                        if (sw_any) begin
                            if (digit_count < DIGITS_MAX) begin
                                entered_amount <= appended_amount;
                                digit_count    <= digit_count + COUNT_W'(1);
                            end else begin
                                error <= 1'b1;
                            end
                        end
                    end
`ifdef WATER_DISPENSER_BACKSPACE_EN
                    else if (delete_edge && (digit_count != '0)) begin
                        entered_amount <= entered_amount / TEN;
                        digit_count    <= digit_count - COUNT_W'(1);
                    end
`endif
                end
                DISPENSE: begin
                    // The cycle just finished had the valve open, so it is
                    // credited even when cancel closes the valve on this edge.
                    if (tick_wrap) begin
                        tick             <= '0;
                        dispensed_amount <= dispensed_next;
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                    if (cancel_edge) begin
                        valve_open     <= 1'b0;
                        busy           <= 1'b0;
                        entered_amount <= '0;
                        digit_count    <= '0;
                        state          <= ENTRY;
                    end else if (tick_wrap && (dispensed_next == entered_amount)) begin
                        valve_open <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    entered_amount <= '0;
                    digit_count    <= '0;
                    state          <= ENTRY;
                end
                default: begin
                    state <= ENTRY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_water_dispenser_controller.sv
// Randomized and directed bench for water_dispenser_controller against a
// pour-time behavioural model (TICKS_PER_ML = 4).
module tb_water_dispenser_controller;

    localparam int T   = 4;
    localparam int MAXA = 2000;
    localparam int MAXD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  switches = '0;
    logic        button_add = 1'b0;
    logic        button_ok = 1'b0;
    logic        button_cancel = 1'b0;
`ifdef WATER_DISPENSER_BACKSPACE_EN
    logic        button_delete = 1'b0;
`endif
    logic [13:0] entered_amount;
    logic [2:0]  digit_count;
    logic [13:0] dispensed_amount;
    logic        valve_open;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    water_dispenser_controller #(
        .SWITCH_COUNT (10),
        .MAX_DIGITS   (MAXD),
        .MAX_AMOUNT   (MAXA),
        .TICKS_PER_ML (T)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .switches         (switches),
        .button_add       (button_add),
        .button_ok        (button_ok),
        .button_cancel    (button_cancel),
`ifdef WATER_DISPENSER_BACKSPACE_EN
        .button_delete    (button_delete),
`endif
        .entered_amount   (entered_amount),
        .digit_count      (digit_count),
        .dispensed_amount (dispensed_amount),
        .valve_open       (valve_open),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a pour is a span of elapsed open cycles; delivered
    // volume is elapsed / T and the pour ends when elapsed reaches amount*T.
    int m_ent = 0, m_cnt = 0, m_disp = 0, m_elapsed = 0;
    bit m_pour = 0, m_done = 0, m_err = 0, m_after_done = 0;
    bit pa = 0, po = 0, pc = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ent = 0; m_cnt = 0; m_disp = 0; m_elapsed = 0;
            m_pour = 0; m_done = 0; m_err = 0; m_after_done = 0;
            pa = 0; po = 0; pc = 0;
        end else begin
            bit ea, eo, ec;
            int digit;
            ea = button_add & ~pa;
            eo = button_ok & ~po;
            ec = button_cancel & ~pc;
            pa = button_add; po = button_ok; pc = button_cancel;
            m_done = 0;
            m_err = 0;
            digit = -1;
            for (int i = 9; i >= 0; i--) if (switches[i]) digit = i;
            if (m_after_done) begin
                m_after_done = 0;
                m_ent = 0; m_cnt = 0;
            end else if (m_pour) begin
                m_elapsed++;
                m_disp = m_elapsed / T;
                if (ec) begin
                    m_pour = 0; m_ent = 0; m_cnt = 0;
                end else if (m_elapsed == m_ent * T) begin
                    m_pour = 0; m_done = 1; m_after_done = 1;
                end
            end else if (ec) begin
                m_ent = 0; m_cnt = 0;
            end else if (eo) begin
                if (m_ent >= 1 && m_ent <= MAXA) begin
                    m_pour = 1; m_elapsed = 0; m_disp = 0;
                end else begin
                    m_err = 1; m_ent = 0; m_cnt = 0;
                end
            end else if (ea && digit >= 0) begin
                if (m_cnt < MAXD) begin
                    m_ent = m_ent * 10 + digit; m_cnt++;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("entered_amount", int'(entered_amount), m_ent);
            chk("digit_count", int'(digit_count), m_cnt);
            chk("dispensed_amount", int'(dispensed_amount), m_disp);
            chk("valve_open", int'(valve_open), int'(m_pour));
            chk("busy", int'(busy), int'(m_pour));
            chk("done", int'(done), int'(m_done));
            chk("error", int'(error), int'(m_err));
        end
    end

    int valve_cnt = 0, done_cnt = 0, err_cnt = 0;
    always @(negedge clock) begin
        if (valve_open) valve_cnt++;
        if (done) done_cnt++;
        if (error) err_cnt++;
    end

    task automatic step();
        @(negedge clock);
        #2;
    endtask

    task automatic add_digit(input int d);
        switches = 10'(1) << d;
        button_add = 1'b1;
        step();
        button_add = 1'b0;
        switches = '0;
        step();
    endtask

    task automatic press_ok();
        button_ok = 1'b1;
        step();
        button_ok = 1'b0;
    endtask

    int v0, d0, e0;

    initial begin
        repeat (3) step();
        chk("reset_valve", int'(valve_open), 0);
        chk("reset_entered", int'(entered_amount), 0);
        chk("reset_dispensed", int'(dispensed_amount), 0);
        chk("reset_flags", int'({busy, done, error}), 0);
        reset = 1'b0;
        step();

        // 37 mL pour: 148 open cycles, one done pulse, entry cleared.
        add_digit(3);
        add_digit(7);
        chk("s1_entered", int'(entered_amount), 37);
        chk("s1_count", int'(digit_count), 2);
        v0 = valve_cnt; d0 = done_cnt;
        press_ok();
        chk("s1_valve_on", int'(valve_open), 1);
        for (int i = 0; i < 400 && done_cnt == d0; i++) step();
        step();
        step();
        chk("s1_open_cycles", valve_cnt - v0, 148);
        chk("s1_done_pulses", done_cnt - d0, 1);
        chk("s1_dispensed", int'(dispensed_amount), 37);
        chk("s1_entry_cleared", int'(entered_amount), 0);

        // Two switches, add held: lowest index once.
        switches = 10'b00_0010_0100;
        button_add = 1'b1;
        repeat (10) step();
        button_add = 1'b0;
        switches = '0;
        step();
        chk("s2_entered", int'(entered_amount), 2);
        chk("s2_count", int'(digit_count), 1);
        button_cancel = 1'b1; step(); button_cancel = 1'b0; step();

        // Full entry, fifth digit rejected, OK above limit rejected.
        for (int i = 0; i < 4; i++) add_digit(9);
        chk("s3_entered", int'(entered_amount), 9999);
        e0 = err_cnt;
        add_digit(5);
        chk("s3_fifth_err", err_cnt - e0, 1);
        chk("s3_kept", int'(entered_amount), 9999);
        press_ok();
        step();
        chk("s3_ok_err", err_cnt - e0, 2);
        chk("s3_cleared", int'(entered_amount), 0);
        chk("s3_no_valve", int'(valve_open), 0);

        // Cancel 12 cycles into a 5 mL pour.
        add_digit(5);
        d0 = done_cnt;
        press_ok();
        repeat (11) step();
        button_cancel = 1'b1;
        step();
        button_cancel = 1'b0;
        step();
        chk("s4_valve", int'(valve_open), 0);
        chk("s4_dispensed", int'(dispensed_amount), 3);
        chk("s4_no_done", done_cnt - d0, 0);
        chk("s4_busy", int'(busy), 0);

        // OK and cancel together: cancel wins.
        add_digit(1);
        add_digit(2);
        e0 = err_cnt;
        button_ok = 1'b1; button_cancel = 1'b1;
        step();
        button_ok = 1'b0; button_cancel = 1'b0;
        step();
        chk("s5_cleared", int'(entered_amount), 0);
        chk("s5_no_valve", int'(valve_open), 0);
        chk("s5_no_err", err_cnt - e0, 0);

        // Asynchronous reset mid-pour.
        add_digit(4);
        press_ok();
        repeat (3) step();
        chk("s6_pouring", int'(valve_open), 1);
        #1 reset = 1'b1;
        #1;
        chk("s6_valve_async", int'(valve_open), 0);
        chk("s6_outputs", int'({entered_amount, digit_count, dispensed_amount, busy, done, error}), 0);
        step();
        reset = 1'b0;
        step();

        // Random traffic, checked every cycle by the model.
        for (int n = 0; n < 15000; n++) begin
            case ($urandom_range(0, 3))
                0: switches = '0;
                1: switches = 10'($urandom_range(0, 1023));
                default: switches = 10'(1) << $urandom_range(0, 9);
            endcase
            button_add    = ($urandom_range(0, 3) == 0);
            button_ok     = ($urandom_range(0, 30) == 0);
            button_cancel = ($urandom_range(0, 250) == 0);
            step();
        end
        button_add = 1'b0; button_ok = 1'b0; button_cancel = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
